// File: rtl/bpred_fetch.sv
// Fetch-stage PC generator with a direct-mapped branch target buffer and 2-bit
// counters; branches resolve in D, and a wrong guess redirects fetch combinationally.
module bpred_fetch #(
  parameter int               WIDTH    = 32,
  parameter int               ENTRIES  = 16,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallF,
  input  logic             stallD,
  input  logic             branchD,
  input  logic             takenD,
  input  logic [WIDTH-1:0] targetD,
  output logic [WIDTH-1:0] pcF,
  output logic [WIDTH-1:0] pcD,
  output logic             predtakenD,
  output logic             mispredictD
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = WIDTH - IDXW - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]    tag_q    [ENTRIES];
  logic [WIDTH-1:0]   target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDXW-1:0]  idx_f;
  logic [TAGW-1:0]  tag_f;
  logic             hit_f;
  logic             predtaken_f;
  logic [WIDTH-1:0] predtarget_f;

  logic [IDXW-1:0]  idx_d;
  logic [TAGW-1:0]  tag_d;
  logic             hit_d;

  logic             validD;
  logic [WIDTH-1:0] predtargetD;
  logic             resolve_d;
  logic [WIDTH-1:0] correct_pc;
  logic [WIDTH-1:0] pc_next;

  // Lookup reads the registered table, so a same-cycle update is never forwarded.
  always_comb begin
    idx_f        = pcF[IDXW+1:2];
    tag_f        = pcF[WIDTH-1:IDXW+2];
    hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    predtaken_f  = hit_f && ctr_q[idx_f][1];
    predtarget_f = target_q[idx_f];
  end

  always_comb begin
    idx_d = pcD[IDXW+1:2];
    tag_d = pcD[WIDTH-1:IDXW+2];
    hit_d = valid_q[idx_d] && (tag_q[idx_d] == tag_d);
  end

  // A predicted-taken non-branch (aliased entry) is also a misprediction.
  always_comb begin
    resolve_d   = validD && !stallD;
    mispredictD = resolve_d &&
                  ((branchD && ((takenD != predtakenD) ||
                                (takenD && predtakenD && (targetD != predtargetD)))) ||
                   (!branchD && predtakenD));
    correct_pc  = (branchD && takenD) ? targetD : pcD + WIDTH'(4);
  end

  always_comb begin
    pc_next = pcF + WIDTH'(4);
    if (mispredictD)      pc_next = correct_pc;
    else if (stallF)      pc_next = pcF;
    else if (predtaken_f) pc_next = predtarget_f;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcF         <= RESET_PC;
      validD      <= 1'b0;
      pcD         <= '0;
      predtakenD  <= 1'b0;
      predtargetD <= '0;
    end else begin
      pcF <= pc_next;
      if (!stallD) begin
        if (mispredictD) begin
          validD      <= 1'b0;
          pcD         <= '0;
          predtakenD  <= 1'b0;
          predtargetD <= '0;
        end else begin
          validD      <= 1'b1;
          pcD         <= pcF;
          predtakenD  <= predtaken_f;
          predtargetD <= predtarget_f;
        end
      end
    end
  end

  // Single write port: train on a hit, allocate on a taken miss, evict an alias.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (resolve_d) begin
      if (branchD) begin
        if (hit_d) begin
          if (takenD) begin
            if (ctr_q[idx_d] != 2'b11) ctr_q[idx_d] <= ctr_q[idx_d] + 2'd1;
            target_q[idx_d] <= targetD;
          end else if (ctr_q[idx_d] != 2'b00) begin
            ctr_q[idx_d] <= ctr_q[idx_d] - 2'd1;
          end
        end else if (takenD) begin
          valid_q[idx_d]  <= 1'b1;
          tag_q[idx_d]    <= tag_d;
          target_q[idx_d] <= targetD;
          ctr_q[idx_d]    <= 2'b10;
        end
      end else if (predtakenD) begin
        valid_q[idx_d] <= 1'b0;
      end
    end
  end

endmodule

// File: doc/bpred_fetch.md
BPRED_FETCH -- requirements
Module: bpred_fetch

Interface
REQ-001 Parameter WIDTH, default 32, PC/target width in bits.
REQ-002 Parameter ENTRIES, default 16, branch-target-buffer depth; power of two, at least 2; IDXW = log2(ENTRIES).
REQ-003 Parameter RESET_PC, default 0, fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stallF  input  1  hold pcF.
REQ-007 stallD  input  1  hold D-stage registers; suppresses resolution.
REQ-008 branchD  input  1  instruction in D is a branch or jump.
REQ-009 takenD  input  1  actual outcome of the D-stage branch; jumps are driven 1.
REQ-010 targetD  input  WIDTH  actual target of the D-stage branch.
REQ-011 pcF  output  WIDTH  current fetch address.
REQ-012 pcD  output  WIDTH  address of the instruction in D.
REQ-013 predtakenD  output  1  prediction made for the instruction in D.
REQ-014 mispredictD  output  1  combinational; F/D flush request, also the pipeline redirect.

Function
REQ-015 Table: ENTRIES entries of {valid, tag, target[WIDTH], ctr[1:0]}; index = pc[IDXW+1:2]; tag = pc[WIDTH-1:IDXW+2]; WIDTH >= IDXW+3.
REQ-016 hitF = valid & tag match at index(pcF); predtakenF = hitF & ctr[1]; predtargetF = entry target.
REQ-017 Lookup is combinational on pcF and uses pre-edge table contents even when the same entry is written that cycle.
REQ-018 D registers {validD, pcD, predtakenD, predtargetD} load {1, pcF, predtakenF, predtargetF} when ~stallD & ~mispredictD; hold when stallD; load {0, 0, 0, 0} when ~stallD & mispredictD.
REQ-019 resolveD = validD & ~stallD.
REQ-020 mispredictD = resolveD & (branchD & (takenD != predtakenD | takenD & predtakenD & targetD != predtargetD) | ~branchD & predtakenD).
REQ-021 Correct PC: targetD if branchD & takenD, else pcD+4.
REQ-022 pcF next-value priority: reset -> RESET_PC; mispredictD -> correct PC; stallF -> hold; predtakenF -> predtargetF; else pcF+4.
REQ-023 PC additions wrap modulo 2^WIDTH.
REQ-024 Update on resolveD & branchD when the entry at index(pcD) is a hit: ctr saturating-increments if takenD, else saturating-decrements (limits 2'b11/2'b00); target <= targetD if takenD.
REQ-025 Update on resolveD & branchD & takenD when the entry misses: allocate {valid=1, tag(pcD), targetD, ctr=2'b10}, replacing any resident entry.
REQ-026 Update on resolveD & branchD & ~takenD when the entry misses: no table write.
REQ-027 Update on resolveD & ~branchD & predtakenD (alias): clear valid at index(pcD).
REQ-028 At most one table write per cycle; no write while stallD.
REQ-029 Latency: prediction redirects at the F->F edge (zero bubble); a mispredict costs exactly one flushed F slot.

Reset
REQ-030 While reset is high at an edge: pcF <= RESET_PC; all valid bits <= 0; validD, pcD, predtakenD, predtargetD <= 0; no table update.
REQ-031 Reset overrides stallF, stallD and mispredictD; asserting it mid-stall or mid-redirect discards all in-flight state.
REQ-032 After reset mispredictD = 0 (validD = 0) and predtakenF = 0 until an allocation occurs.

Verification
REQ-033 Reset, then no stalls and no branches, with WIDTH=32 -> pcF sequence 0, 4, 8, 12; predtakenD = 0; mispredictD never 1.
REQ-034 Branch at 0x10, taken to 0x40, first encounter -> mispredictD=1 in its D cycle; next pcF=0x40; slot 0x14 flushed (validD=0); entry allocated with ctr=2'b10. Second encounter -> pcF 0x10 then 0x40, no mispredict.
REQ-035 The same branch resolved not-taken three times from ctr=2'b11 -> ctr 10, 01, 00; the first not-taken causes a mispredict with redirect to 0x14; predtakenF=0 from ctr=01.
REQ-036 Hit predicts taken to 0x40 while D reports non-branch at that pc (alias) -> mispredictD=1, pcF <= pcD+4, entry invalidated.
REQ-037 stallD=1 for 3 cycles with a mispredicting branch in D -> mispredictD=0, pcF held under stallF, no table write; on release mispredictD=1 for one cycle.
REQ-038 WIDTH=16, ENTRIES=4, pcF=0xFFFC, no prediction -> next pcF=0x0000; reset asserted during a redirect cycle -> pcF=RESET_PC, all entries invalid.
